module_program_loader: RTL and testbench

//  Writer side of the instruction-memory programming port (prog/addr/code).

---
 rtl/program_loader_pkg.sv | 24 ++
 rtl/program_loader_if.sv | 18 +
 rtl/program_loader_byte_packer.sv | 45 ++++
 rtl/module_program_loader.sv | 120 ++++++++++++
 tb/tb_module_program_loader.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and sizing helpers for the instruction-memory program loader.
//   state_t          : loader FSM states (CHECK is only reachable with CHECKSUM_EN)
//   BYTES_PER_WORD   : bytes per instruction word at the default sizes
//   BYTE_CNT_W       : width of the in-word byte counter at the default sizes
//   bytes_per_word() / cnt_width() : same quantities for arbitrary parameters
package program_loader_pkg;

  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR, CHECK} state_t;

  localparam int WORD_SIZE_DEF  = 32;
  localparam int BYTE_BITS_DEF  = 8;
  localparam int BYTES_PER_WORD = WORD_SIZE_DEF / BYTE_BITS_DEF;
  localparam int BYTE_CNT_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  function automatic int bytes_per_word(int word_size, int byte_bits);
    return word_size / byte_bits;
  endfunction

  // A one-byte word still needs a 1-bit counter to stay a legal vector.
  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Loader bus: byte stream in (valid/ready) plus instruction-memory write port out.
//   master : stream source / memory observer (drives byte_valid, byte_data)
//   slave  : the loader (drives byte_ready, prog, addr, code)
interface program_loader_if #(
  parameter int ADDRESS_BITS = 32,
  parameter int WORD_SIZE    = 32,
  parameter int BYTE_BITS    = 8
);
  logic                    byte_valid;
  logic [BYTE_BITS-1:0]    byte_data;
  logic                    byte_ready;
  logic                    prog;
  logic [ADDRESS_BITS-1:0] addr;
  logic [WORD_SIZE-1:0]    code;

  modport master (output byte_valid, byte_data, input byte_ready, prog, addr, code);
  modport slave  (input byte_valid, byte_data, output byte_ready, prog, addr, code);
endinterface

// File: rtl/program_loader_byte_packer.sv
// module_byte_packer: packs a byte stream big-endian into words.
//   clk, rst_n  : clock, async active-low reset
//   in_valid    : a byte transfers this cycle
//   in_byte     : the byte
//   clear       : drop any partial word and restart at byte 0
//   word        : shift register; holds the full word the cycle after the last byte
//   word_valid  : combinational pulse on the transfer that completes a word
module module_byte_packer
  import program_loader_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int BYTE_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [BYTE_BITS-1:0] in_byte,
  input  logic                 clear,
  output logic [WORD_SIZE-1:0] word,
  output logic                 word_valid
);
  localparam int BPW = bytes_per_word(WORD_SIZE, BYTE_BITS);
  localparam int CW  = cnt_width(BPW);

  logic [CW-1:0] cnt;
  logic          last;

  assign last       = (cnt == CW'(BPW - 1));
  assign word_valid = in_valid && last;

  // Shifting left means the first byte of a word ends up in the top lane
  // once BPW bytes have gone in; older bytes simply fall off the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      cnt  <= '0;
    end else if (clear) begin
      word <= '0;
      cnt  <= '0;
    end else if (in_valid) begin
      word <= (word << BYTE_BITS) | WORD_SIZE'(in_byte);
      cnt  <= last ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/module_program_loader.sv
// module_program_loader: writes a byte-streamed program image into instruction
// memory at word addresses 0..length-1 and holds the CPU until it is complete.
//   clk, rst_n         : clock, async active-low reset
//   start, length      : begin a load of `length` words (ignored while loading)
//   bus (slave)        : byte_valid/byte_data/byte_ready stream, prog/addr/code write port
//   busy               : RECV or WRITE
//   done / error       : sticky completion / abort flags, cleared by an accepted start
//   cpu_run            : CPU release, equal to done
// Optional feature macro CHECKSUM_EN: one extra trailing word must equal the
// mod-2^WORD_SIZE sum of the image words, else the load ends in ERROR.
module module_program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDRESS_BITS = 32,
  parameter int WORD_SIZE    = 32,
  parameter int BYTE_BITS    = 8,
  parameter int MEMORY       = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] length,
  program_loader_if.slave         bus,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    cpu_run
);
  state_t                  state, state_nxt;
  logic [ADDRESS_BITS-1:0] len_q, wcnt;
  logic [WORD_SIZE-1:0]    word;
  logic                    word_valid, xfer, start_ok;

  assign start_ok = start && (state == IDLE || state == DONE || state == ERROR);
  assign xfer     = bus.byte_valid && bus.byte_ready;
  assign cpu_run  = done;

  module_byte_packer #(.WORD_SIZE(WORD_SIZE), .BYTE_BITS(BYTE_BITS)) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (xfer),
    .in_byte    (bus.byte_data),
    .clear      (start_ok),
    .word       (word),
    .word_valid (word_valid)
  );

`ifdef CHECKSUM_EN
  localparam state_t IMG_END = CHECK;
  logic [WORD_SIZE-1:0] acc, cs_word;
  // The checksum word is compared on the cycle its last byte arrives, so
  // fold that byte in here rather than waiting for the packer register.
  assign cs_word = (word << BYTE_BITS) | WORD_SIZE'(bus.byte_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              acc <= '0;
    else if (start_ok)       acc <= '0;
    else if (state == WRITE) acc <= acc + word;
  end
`else
  localparam state_t IMG_END = DONE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      len_q <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        len_q <= length;
        wcnt  <= '0;
      end else if (state == WRITE) begin
        wcnt  <= wcnt + ADDRESS_BITS'(1);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.byte_ready = 1'b0;
    bus.prog       = 1'b0;
    bus.addr       = '0;
    bus.code       = '0;
    busy           = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        done  = (state == DONE);
        error = (state == ERROR);
        if (start) begin
          if (length > ADDRESS_BITS'(MEMORY)) state_nxt = ERROR;
          else if (length == '0)              state_nxt = IMG_END;
          else                                state_nxt = RECV;
        end
      end
      RECV: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
        if (word_valid) state_nxt = WRITE;
      end
      WRITE: begin
        bus.prog = 1'b1;
        bus.addr = wcnt;
        bus.code = word;
        busy     = 1'b1;
        state_nxt = (wcnt + ADDRESS_BITS'(1) == len_q) ? IMG_END : RECV;
      end
`ifdef CHECKSUM_EN
      CHECK: begin
        bus.byte_ready = 1'b1;
        if (word_valid) state_nxt = (cs_word == acc) ? DONE : ERROR;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_module_program_loader.sv
module tb_module_program_loader;
  localparam int AB = 32, WS = 32, BB = 8, MEM = 1024;
`ifdef CHECKSUM_EN
  localparam bit CS_ON = 1'b1;
`else
  localparam bit CS_ON = 1'b0;
`endif

  typedef struct { logic [31:0] addr; logic [31:0] code; } wr_t;
  typedef wr_t        wr_q_t[$];
  typedef logic [7:0] byte_q_t[$];
  typedef struct { logic [31:0] len; int gap; bit fixed; bit bad_cs; bit exp_done; } vec_t;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] length = '0;
  logic        busy, done, error, cpu_run;
  int          checks = 0, fails = 0, ready_bad = 0;
  wr_t         got[$];

  program_loader_if #(.ADDRESS_BITS(AB), .WORD_SIZE(WS), .BYTE_BITS(BB)) bus ();

  module_program_loader #(.ADDRESS_BITS(AB), .WORD_SIZE(WS), .BYTE_BITS(BB), .MEMORY(MEM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .length(length), .bus(bus),
    .busy(busy), .done(done), .error(error), .cpu_run(cpu_run));

  always #5 clk = ~clk;

  // Memory-side observer: log every write and flag any stream acceptance during it.
  always @(negedge clk) begin
    if (bus.prog) begin
      got.push_back('{addr: bus.addr, code: bus.code});
      if (bus.byte_ready !== 1'b0) ready_bad++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, bus.byte_ready, 0);
    chk({tag, "_prog"},  bus.prog, 0);
    chk({tag, "_addr"},  bus.addr, 0);
    chk({tag, "_code"},  bus.code, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_cpu_run"}, cpu_run, 0);
  endtask

  // Build the byte stream for an image; with the checksum option a trailing
  // word is appended (the correct sum, or a deliberately wrong one).
  task automatic make_image(input logic [31:0] len, input bit fixed, input bit bad, output byte_q_t q);
    logic [7:0]  fx[8];
    logic [31:0] s, cs;
    fx = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h01, 8'h10, 8'h00};
    q = {};
    if (len > MEM) return;
    for (int i = 0; i < int'(len) * 4; i++) q.push_back(fixed ? fx[i % 8] : 8'($urandom));
    s = 0;
    for (int w = 0; w < int'(len); w++) s = s + {q[4*w], q[4*w+1], q[4*w+2], q[4*w+3]};
    cs = bad ? ((s == 0) ? 32'd1 : 32'd0) : s;
    if (CS_ON) for (int k = 3; k >= 0; k--) q.push_back(8'((cs >> (8 * k)) & 32'hFF));
  endtask

  // Reference model: words are base-256 big-endian numbers of each 4-byte group.
  task automatic model(input logic [31:0] len, input byte_q_t q, output wr_q_t exp, output bit exp_done);
    longint sum = 0, v, cs;
    exp = {};
    exp_done = 1'b0;
    if (len > MEM) return;
    for (int w = 0; w < int'(len); w++) begin
      v = q[4*w] * 64'd16777216 + q[4*w+1] * 64'd65536 + q[4*w+2] * 64'd256 + q[4*w+3];
      exp.push_back('{addr: w, code: 32'(v)});
      sum = (sum + v) % 64'd4294967296;
    end
    exp_done = 1'b1;
    if (CS_ON) begin
      cs = q[4*len] * 64'd16777216 + q[4*len+1] * 64'd65536 + q[4*len+2] * 64'd256 + q[4*len+3];
      exp_done = (cs == sum);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit to);
    to = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      if (bus.byte_ready) return;   // transfers on the coming rising edge
    end
    to = 1'b1;
  endtask

  task automatic do_start(input logic [31:0] len);
    @(negedge clk);
    start  = 1'b1;
    length = len;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle before each byte, 2 random 0..2
  task automatic run_case(input string name, input logic [31:0] len, input byte_q_t q,
                          input int gap_mode, input bit exp_done_tbl, input bit use_tbl);
    int    base, n;
    bit    to, any_to, exp_done;
    wr_q_t exp;
    base = got.size();
    do_start(len);
    if (len > MEM) chk({name, "_err_next_cycle"}, error, 1);
    any_to = 1'b0;
    foreach (q[i]) begin
      send_byte(q[i], (gap_mode == 2) ? $urandom_range(0, 2) : gap_mode, to);
      any_to |= to;
      if (to) break;
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    for (int c = 0; c < 30 && !(done || error); c++) @(negedge clk);
    model(len, q, exp, exp_done);
    if (use_tbl) exp_done = exp_done_tbl;
    chk({name, "_timeout"}, any_to, 0);
    chk({name, "_done"},    done, exp_done);
    chk({name, "_error"},   error, !exp_done);
    chk({name, "_cpu_run"}, cpu_run, exp_done);
    chk({name, "_busy"},    busy, 0);
    n = got.size() - base;
    chk({name, "_nwrites"}, n, exp.size());
    for (int i = 0; i < n && i < exp.size(); i++) begin
      chk($sformatf("%s_addr%0d", name, i), got[base+i].addr, exp[i].addr);
      chk($sformatf("%s_code%0d", name, i), got[base+i].code, exp[i].code);
    end
  endtask

  initial begin
    vec_t    tv[10];
    byte_q_t q;
    bit      to;
    int      base;

    tv[0] = '{len: 2,            gap: 0, fixed: 1, bad_cs: 0, exp_done: 1};
    tv[1] = '{len: 2,            gap: 1, fixed: 1, bad_cs: 0, exp_done: 1};
    tv[2] = '{len: 1025,         gap: 0, fixed: 0, bad_cs: 0, exp_done: 0};
    tv[3] = '{len: 0,            gap: 0, fixed: 0, bad_cs: 0, exp_done: 1};
    tv[4] = '{len: 3,            gap: 2, fixed: 0, bad_cs: 0, exp_done: 1};
    tv[5] = '{len: 1,            gap: 0, fixed: 0, bad_cs: 0, exp_done: 1};
    tv[6] = '{len: 32'hFFFFFFFF, gap: 0, fixed: 0, bad_cs: 0, exp_done: 0};
    tv[7] = '{len: 1024,         gap: 0, fixed: 0, bad_cs: 0, exp_done: 1};
    tv[8] = '{len: 2,            gap: 0, fixed: 1, bad_cs: 1, exp_done: !CS_ON};
    tv[9] = '{len: 4,            gap: 1, fixed: 0, bad_cs: 0, exp_done: 1};

    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("reset_released");

    foreach (tv[i]) begin
      make_image(tv[i].len, tv[i].fixed, tv[i].bad_cs, q);
      run_case($sformatf("vec%0d", i), tv[i].len, q, tv[i].gap, tv[i].exp_done, 1'b1);
    end

    for (int r = 0; r < 6; r++) begin
      logic [31:0] len = $urandom_range(1, 6);
      make_image(len, 1'b0, 1'(CS_ON ? $urandom_range(0, 1) : 0), q);
      run_case($sformatf("rand%0d", r), len, q, $urandom_range(0, 2), 1'b0, 1'b0);
    end

    // Async reset in the middle of word 1, then a fresh load over address 0.
    make_image(2, 1'b0, 1'b0, q);
    do_start(2);
    for (int i = 0; i < 6; i++) send_byte(q[i], 0, to);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("midload_reset");
    @(negedge clk);
    rst_n = 1'b1;
    base = got.size();
    make_image(1, 1'b0, 1'b0, q);
    run_case("after_reset", 1, q, 0, 1'b1, 1'b1);
    chk("after_reset_single_write", got.size() - base, 1);

    chk("ready_low_during_write", ready_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end
endmodule
